// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter.
//   tx_state_t : frame FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS  : payload width of one frame
//   BIT_IDX_W  : width of the payload bit index
package serial_frame_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage : serial_frame_pkg

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: measures out one serial bit period of N clock cycles.
//   clock   : single clock, rising edge
//   reset   : synchronous active-high reset, clears the hold counter
//   restart : holds the counter at 0 so the next period starts cleanly
//   tick    : high on the last cycle (count == N-1) of every bit period
module bit_timer #(
  parameter int N = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  // N=1 still needs a one-bit counter; it simply never leaves 0.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always updated with non-blocking assignments
  // so every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Decoded from the counter register only, so no input reaches tick.
  assign tick = (count == LAST);

endmodule : bit_timer

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends an 8-bit word as a 10-bit frame on a serial line:
// one start bit (1), eight data bits MSB first, one stop bit (0), each bit
// held for N clock cycles.
//   clock   : single clock, rising edge
//   reset   : synchronous active-high reset, aborts any frame in flight
//   data_in : parallel word, captured on an accepted handshake only
//   valid   : producer has a word to send
//   ready   : block can accept a word (IDLE only), registered
//   y       : serial line, registered, idles low
//   busy    : high for every START, DATA and STOP cycle, registered
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int N = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       y,
  output logic       busy
);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shreg;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic                   tick;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  // The timer is parked at 0 while idle, so START always gets a full period.
  bit_timer #(.N(N)) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the shift register is cleared too, so no stale payload bits
      // survive an aborted frame.
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      y       <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          y     <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          // ready is the registered flag, so the cycle straight after reset
          // release cannot accept a word.
          if (valid && ready) begin
            shreg <= data_in;
            state <= START;
            y     <= 1'b1;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            y       <= shreg[DATA_BITS-1];
            shreg   <= shreg << 1;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              y     <= 1'b0;
            end else begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
              y       <= shreg[DATA_BITS-1];
              shreg   <= shreg << 1;
            end
          end
        end

        STOP: begin
          // Returning with ready already high gives exactly one IDLE cycle
          // between frames when valid is held.
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_frame_tx

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx. Three instances cover
// N=3 (index 0), N=1 (index 1) and N=255 (index 2); each is driven on its
// own and held in reset while the others are exercised.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst   [3];
  logic       vld   [3];
  logic [7:0] din   [3];
  logic       rdy_o [3];
  logic       y_o   [3];
  logic       bsy_o [3];

  int checks;
  int errors;

  serial_frame_tx #(.N(3)) dut_n3 (
    .clock(clk), .reset(rst[0]), .data_in(din[0]), .valid(vld[0]),
    .ready(rdy_o[0]), .y(y_o[0]), .busy(bsy_o[0])
  );

  serial_frame_tx #(.N(1)) dut_n1 (
    .clock(clk), .reset(rst[1]), .data_in(din[1]), .valid(vld[1]),
    .ready(rdy_o[1]), .y(y_o[1]), .busy(bsy_o[1])
  );

  serial_frame_tx #(.N(255)) dut_n255 (
    .clock(clk), .reset(rst[2]), .data_in(din[2]), .valid(vld[2]),
    .ready(rdy_o[2]), .y(y_o[2]), .busy(bsy_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    check({tag, "_y"},     32'(y_o[s]),   32'd0);
    check({tag, "_busy"},  32'(bsy_o[s]), 32'd0);
    check({tag, "_ready"}, 32'(rdy_o[s]), 32'd1);
  endtask

  // Called while sampling the first START cycle. Walks all 10*n frame
  // cycles and returns sampling the cycle after the frame. With disturb set,
  // valid is pulsed and data_in forced to 0xFF in the middle of the data bits.
  task automatic check_frame(input int s, input int n, input logic [7:0] b,
                             input bit disturb, input string tag);
    logic exp_y;
    int   c;
    c = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_y = 1'b1;
      else if (i == 9) exp_y = 1'b0;
      else             exp_y = b[8-i];
      for (int j = 0; j < n; j++) begin
        check($sformatf("%s_y_bit%0d_c%0d", tag, i, c), 32'(y_o[s]), 32'(exp_y));
        check($sformatf("%s_busy_c%0d", tag, c),  32'(bsy_o[s]), 32'd1);
        check($sformatf("%s_ready_c%0d", tag, c), 32'(rdy_o[s]), 32'd0);
        if (disturb && c == 12) begin
          vld[s] = 1'b1;
          din[s] = 8'hFF;
        end
        if (disturb && c == 13) vld[s] = 1'b0;
        c++;
        step();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      din[i] = 8'h00;
    end

    // ---- Reset state (N=3) ----
    step();
    step();
    check("rst_y",     32'(y_o[0]),   32'd0);
    check("rst_busy",  32'(bsy_o[0]), 32'd0);
    check("rst_ready", 32'(rdy_o[0]), 32'd0);
    rst[0] = 1'b0;
    step();
    check_idle(0, "rel");

    // ---- 0xA5 single pulse, N=3 ----
    vld[0] = 1'b1;
    din[0] = 8'hA5;
    step();
    vld[0] = 1'b0;
    check_frame(0, 3, 8'hA5, 1'b0, "a5");
    check_idle(0, "a5_after");

    // ---- reset and valid together: nothing captured ----
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    din[0] = 8'h55;
    step();
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    check("rv_y",     32'(y_o[0]),   32'd0);
    check("rv_busy",  32'(bsy_o[0]), 32'd0);
    check("rv_ready", 32'(rdy_o[0]), 32'd0);
    step();
    check_idle(0, "rv_rel");
    for (int k = 0; k < 4; k++) begin
      step();
      check_idle(0, $sformatf("rv_quiet%0d", k));
    end

    // ---- 0x3C with valid/data disturbance mid-frame ----
    vld[0] = 1'b1;
    din[0] = 8'h3C;
    step();
    vld[0] = 1'b0;
    check_frame(0, 3, 8'h3C, 1'b1, "3c");
    for (int k = 0; k < 4; k++) begin
      check_idle(0, $sformatf("3c_nosecond%0d", k));
      step();
    end

    // ---- reset in the 12th busy cycle, then 0x81 ----
    vld[0] = 1'b1;
    din[0] = 8'hC3;
    step();
    vld[0] = 1'b0;
    for (int k = 1; k < 12; k++) begin
      check($sformatf("ab_busy%0d", k), 32'(bsy_o[0]), 32'd1);
      step();
    end
    check("ab_busy12", 32'(bsy_o[0]), 32'd1);
    rst[0] = 1'b1;
    step();
    check("ab_y",     32'(y_o[0]),   32'd0);
    check("ab_busy",  32'(bsy_o[0]), 32'd0);
    check("ab_ready", 32'(rdy_o[0]), 32'd0);
    rst[0] = 1'b0;
    step();
    check_idle(0, "ab_rel");
    vld[0] = 1'b1;
    din[0] = 8'h81;
    step();
    vld[0] = 1'b0;
    check_frame(0, 3, 8'h81, 1'b0, "81");
    check_idle(0, "81_after");
    rst[0] = 1'b1;

    // ---- N=1 back-to-back with valid held high ----
    rst[1] = 1'b0;
    step();
    check_idle(1, "n1_rel");
    vld[1] = 1'b1;
    din[1] = 8'h00;
    step();
    din[1] = 8'hFF;
    check_frame(1, 1, 8'h00, 1'b0, "n1_00");
    check_idle(1, "n1_gap");
    step();
    vld[1] = 1'b0;
    check_frame(1, 1, 8'hFF, 1'b0, "n1_ff");
    check_idle(1, "n1_after");
    rst[1] = 1'b1;

    // ---- N=255, 0x80 ----
    rst[2] = 1'b0;
    step();
    check_idle(2, "n255_rel");
    vld[2] = 1'b1;
    din[2] = 8'h80;
    step();
    vld[2] = 1'b0;
    check_frame(2, 255, 8'h80, 1'b0, "n255");
    check_idle(2, "n255_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_frame_tx
